int_issue_ctrl: RTL and testbench
=================================

# int_issue_ctrl

Integer issue controller directly downstream of the integer instruction queue. It pops one entry at a time from the queue's read port and holds it. It checks source and destination registers against a 32-entry busy scoreboard, then issues the entry to the integer ALU over a valid/ready handshake. Writeback notifications from the ALU clear scoreboard bits.

## Interface
- OP_W, 4, width of the op tag field.
- REG_W, 5, register index width. Fixed at 5; the scoreboard has 2^REG_W = 32 bits.
- ENTRY_W, OP_W+3*REG_W (19), queue entry width. The queue is instantiated with BIT_LEN = ENTRY_W.

Ports:
- clk_in  in  1  clock. All state updates on the rising edge.
- reset_in  in  1  synchronous, active-high reset.
- q_empty  in  1  queue empty flag (undelayed).
- q_rd_data  in  ENTRY_W  queue read data, registered inside the queue.
- q_rd_enable  out  1  queue pop request.
- wb_valid  in  1  ALU writeback strobe.
- wb_rd  in  REG_W  writeback destination register.
- alu_ready  in  1  ALU can accept an issue this cycle.
- issue_valid  out  1  held entry is hazard-free and offered to the ALU.
- issue_op  out  OP_W  op tag of the held entry.
- issue_rd, issue_rs1, issue_rs2  out  REG_W each  register fields of the held entry.
- stall  out  1  an entry is held but blocked by a hazard.
- busy_vec  out  32  scoreboard, bit n = register xn has a pending write.

## Operation
- Entry layout, MSB first: op [ENTRY_W-1 -: OP_W], rd, rs1, rs2 (rs2 in bits [4:0]).
- FSM states are IDLE, POP, WAIT and HOLD.
  - IDLE: if !q_empty, next state is POP; otherwise stay.
  - POP: q_rd_enable = 1 for exactly this cycle. Next state is WAIT unconditionally.
  - WAIT: q_rd_data is valid. At the edge ending WAIT, q_rd_data is captured into the hold register.
    - Captured value == 0: the entry is a bubble (the queue refuses to pop zero entries). Drop it and go to IDLE.
    - Otherwise go to HOLD.
  - HOLD: evaluate hazards.
    - issue_valid = no hazard.
    - stall = hazard.
    - Fire = issue_valid && alu_ready. On fire, go to POP if !q_empty, else IDLE.
    - If there is no fire, stay in HOLD with all fields stable.
- Hazard rule: register r is blocked iff r != 0 && busy_vec[r] && !(wb_valid && wb_rd == r).
  - A hazard exists if rs1, rs2 or rd is blocked.
  - A same-cycle writeback of a register makes that register ready in that cycle.
- Scoreboard update, every edge:
  - If wb_valid && wb_rd != 0, clear bit wb_rd.
  - Then, on fire with rd != 0, set bit rd.
  - If both target the same register, the set wins.
  - Bit 0 is always 0.
- The issue_* fields always reflect the hold register and are meaningful only while issue_valid is 1.
- q_rd_enable is asserted only in POP, and POP is entered only when q_empty was 0 in the previous cycle. The block never pops an empty queue.

## Timing
- Reset (reset_in high at an edge), taking priority over everything else:
  - state = IDLE, hold register = 0, busy_vec = 0.
  - q_rd_enable = 0, issue_valid = 0, stall = 0, and all issue_* fields = 0.
  - Reset asserted in any state discards a held or in-flight entry. An entry already popped from the queue is lost; the queue is reset together with this block.
- Pop-to-offer latency: if q_empty falls before edge 0, POP is active in cycle 1 and WAIT in cycle 2. issue_valid is earliest in cycle 3.
- Sustained throughput is one issue per 3 cycles (HOLD → POP → WAIT → HOLD).
- A hazard-free entry issues in its first HOLD cycle if alu_ready is 1. Otherwise it waits with no timeout.
- wb_valid is sampled every cycle in every state, including reset-free IDLE, POP and WAIT.
- Outputs q_rd_enable, issue_valid and stall are decoded from the current state and the inputs in the same cycle. There is no additional register stage.

## Test plan
- Reset check: apply reset mid-HOLD with busy_vec = 0x0000_0010. Required response: next cycle state IDLE, busy_vec = 0, issue_valid = 0, q_rd_enable = 0.
- Single entry: queue holds {op=3, rd=5, rs1=1, rs2=2}, alu_ready = 1.
  - q_rd_enable is high exactly one cycle and issue_valid is high 2 cycles later.
  - issue_op = 3, issue_rd = 5.
  - After fire, busy_vec = 0x0000_0020.
- RAW stall: with x5 busy, pop {rd=6, rs1=5}. Required response: stall = 1 and issue_valid = 0 until wb_valid = 1 with wb_rd = 5. Issue occurs in that same cycle; afterwards busy_vec = 0x0000_0040.
- Same-register set/clear: the HOLD entry has rd = 7, x7 is busy, and wb_rd = 7 arrives with alu_ready = 1. Required response: fire in that cycle, and busy_vec[7] = 1 afterwards.
- x0 and bubble handling:
  - An entry with rd = 0 issues without setting any scoreboard bit.
  - A zero entry in q_rd_data during WAIT returns the FSM to IDLE with no issue_valid.
- Backpressure: hold alu_ready = 0 for 10 cycles with a ready entry. Required response: issue_valid stays at 1 with fields stable, no further q_rd_enable, and fire on the first cycle alu_ready = 1.

Source files
------------

// File: rtl/int_issue_ctrl.sv
// Integer issue controller: pops one queue entry at a time, checks it against a
// 32-entry busy scoreboard and offers it to the ALU over a valid/ready handshake.
module int_issue_ctrl #(
    parameter int OP_W    = 4,
    parameter int REG_W   = 5,
    parameter int ENTRY_W = OP_W + 3 * REG_W
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               q_empty,
    input  logic [ENTRY_W-1:0] q_rd_data,
    output logic               q_rd_enable,
    input  logic               wb_valid,
    input  logic [REG_W-1:0]   wb_rd,
    input  logic               alu_ready,
    output logic               issue_valid,
    output logic [OP_W-1:0]    issue_op,
    output logic [REG_W-1:0]   issue_rd,
    output logic [REG_W-1:0]   issue_rs1,
    output logic [REG_W-1:0]   issue_rs2,
    output logic               stall,
    output logic [31:0]        busy_vec
);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        WAIT,
        HOLD
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ENTRY_W-1:0] hold;
    logic [31:0]        busy_next;
    logic               hazard;
    logic               fire;

    // A register is ready if it is x0, not pending, or being written back right now.
    function automatic logic is_blocked(input logic [REG_W-1:0] r,
                                        input logic [31:0]      busy,
                                        input logic             wbv,
                                        input logic [REG_W-1:0] wbr);
        return (r != '0) && busy[r] && !(wbv && (wbr == r));
    endfunction

    assign issue_op  = hold[ENTRY_W-1 -: OP_W];
    assign issue_rd  = hold[3*REG_W-1 -: REG_W];
    assign issue_rs1 = hold[2*REG_W-1 -: REG_W];
    assign issue_rs2 = hold[REG_W-1:0];

    assign hazard = is_blocked(issue_rd,  busy_vec, wb_valid, wb_rd)
                 || is_blocked(issue_rs1, busy_vec, wb_valid, wb_rd)
                 || is_blocked(issue_rs2, busy_vec, wb_valid, wb_rd);

    always_comb begin
        state_next  = state;
        q_rd_enable = 1'b0;
        issue_valid = 1'b0;
        stall       = 1'b0;
        fire        = 1'b0;
        case (state)
            IDLE: begin
                if (!q_empty) state_next = POP;
            end
            POP: begin
                q_rd_enable = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                state_next = (q_rd_data == '0) ? IDLE : HOLD;
            end
            HOLD: begin
                issue_valid = !hazard;
                stall       = hazard;
                fire        = !hazard && alu_ready;
                if (fire) state_next = q_empty ? IDLE : POP;
            end
            default: state_next = IDLE;
        endcase
        // Keep the handshakes quiet while reset is pending so nothing is lost mid-reset.
        if (reset_in) begin
            q_rd_enable = 1'b0;
            issue_valid = 1'b0;
            stall       = 1'b0;
            fire        = 1'b0;
        end
    end

    // Writeback clears first, then an issuing rd sets, so the set wins on a tie.
    always_comb begin
        busy_next = busy_vec;
        if (wb_valid && (wb_rd != '0)) busy_next[wb_rd] = 1'b0;
        if (fire && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state    <= IDLE;
            hold     <= '0;
            busy_vec <= '0;
        end else begin
            state    <= state_next;
            busy_vec <= busy_next;
            if (state == WAIT) hold <= q_rd_data;
        end
    end

endmodule

// File: tb/tb_int_issue_ctrl.sv
// Randomized bench for int_issue_ctrl: a small registered-read queue feeds the DUT
// and a flag-based reference model predicts every output cycle by cycle.
module tb_int_issue_ctrl;

    logic        clk_in;
    logic        reset_in;
    logic        q_empty;
    logic [18:0] q_rd_data;
    logic        q_rd_enable;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        alu_ready;
    logic        issue_valid;
    logic [3:0]  issue_op;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        stall;
    logic [31:0] busy_vec;

    int checks   = 0;
    int failures = 0;

    // Queue contents and the value its read register takes after the next edge.
    logic [18:0] fifo[$];
    logic [18:0] next_rd_data;

    // Reference model: what is in flight, the held entry and the pending-write set.
    bit          m_pop_now;
    bit          m_data_now;
    bit          m_held;
    logic [18:0] m_entry;
    bit          m_busy[32];

    int_issue_ctrl dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .q_empty     (q_empty),
        .q_rd_data   (q_rd_data),
        .q_rd_enable (q_rd_enable),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .alu_ready   (alu_ready),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .stall       (stall),
        .busy_vec    (busy_vec)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    function automatic bit reg_blocked(input int r);
        return (r != 0) && m_busy[r] && !(wb_valid && (int'(wb_rd) == r));
    endfunction

    function automatic logic [31:0] model_busy_word();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) w[i] = m_busy[i];
        return w;
    endfunction

    task automatic model_reset();
        m_pop_now  = 0;
        m_data_now = 0;
        m_held     = 0;
        m_entry    = '0;
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
    endtask

    task automatic applyStimulus(input int cycle);
        logic [18:0] e;
        q_rd_data = next_rd_data;
        if (reset_in) begin
            fifo.delete();
            q_rd_data    = '0;
            next_rd_data = '0;
        end
        if (fifo.size() < 4 && $urandom_range(0, 99) < 40) begin
            if ($urandom_range(0, 99) < 6) e = '0;
            else e = {4'($urandom_range(0, 15)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fifo.push_back(e);
        end
        q_empty   = (fifo.size() == 0);
        wb_valid  = ($urandom_range(0, 99) < 50);
        wb_rd     = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                : 5'($urandom_range(0, 7));
        alu_ready = ($urandom_range(0, 99) < 70);
        reset_in  = (cycle < 3) || ($urandom_range(0, 249) == 0);
    endtask

    initial begin
        bit haz;
        bit exp_valid;
        bit fire;
        bit next_pop;
        reset_in     = 1'b1;
        q_empty      = 1'b1;
        q_rd_data    = '0;
        next_rd_data = '0;
        wb_valid     = 1'b0;
        wb_rd        = '0;
        alu_ready    = 1'b0;
        model_reset();

        for (int cycle = 0; cycle < 4000; cycle++) begin
            @(negedge clk_in);
            haz       = m_held && (reg_blocked(int'(m_entry[14:10])) ||
                                   reg_blocked(int'(m_entry[9:5]))   ||
                                   reg_blocked(int'(m_entry[4:0])));
            exp_valid = m_held && !haz;
            if (!reset_in) begin
                checkOutput("q_rd_enable", 32'(q_rd_enable), 32'(m_pop_now));
                checkOutput("issue_valid", 32'(issue_valid), 32'(exp_valid));
                checkOutput("stall",       32'(stall),       32'(haz));
                checkOutput("busy_vec",    busy_vec,         model_busy_word());
                checkOutput("issue_fields",
                            32'({issue_op, issue_rd, issue_rs1, issue_rs2}),
                            32'(m_entry));
            end

            if (reset_in) begin
                model_reset();
            end else begin
                fire = exp_valid && alu_ready;
                if (wb_valid && wb_rd != 0) m_busy[wb_rd] = 0;
                if (fire && m_entry[14:10] != 0) m_busy[m_entry[14:10]] = 1;
                next_pop = !q_empty && ((!m_held && !m_pop_now && !m_data_now) || fire);
                if (m_data_now) begin
                    m_entry = q_rd_data;
                    m_held  = (q_rd_data != '0);
                end
                if (fire) m_held = 0;
                m_data_now = m_pop_now;
                m_pop_now  = next_pop;
                if (q_rd_enable && fifo.size() > 0) next_rd_data = fifo.pop_front();
            end

            @(posedge clk_in);
            #1;
            applyStimulus(cycle);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
